// File: rtl/glyph_fetch_arbiter_pkg.sv
// rtl/glyph_fetch_arbiter_pkg.sv - shared widths, glyph base addresses, FSM states and round-robin helper
//
// Purpose : common definitions for the glyph fetch arbiter slice.
// Contents: default ROM/burst widths, glyph base addresses, FSM state type,
//           rr_wrap() helper that walks requester indices modulo NUM_REQ.

package glyph_fetch_arbiter_pkg;

    localparam int GLYPH_ADDR_WIDTH = 12;
    localparam int GLYPH_DATA_WIDTH = 24;
    localparam int GLYPH_LEN_WIDTH  = 5;

    // Mario glyphs occupy the bottom of the ROM, obstacle glyphs start at 2560.
    localparam logic [GLYPH_ADDR_WIDTH-1:0] MARIO_BASE    = 12'd0;
    localparam logic [GLYPH_ADDR_WIDTH-1:0] OBSTACLE_BASE = 12'd2560;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } fsm_state_t;

    // (base + off) mod n, valid for base < n and off <= n.
    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/glyph_fetch_arbiter_if.sv
// rtl/glyph_fetch_arbiter_if.sv - requester/ROM/response bundle of the glyph fetch arbiter
//
// Purpose : groups the requester handshake, ROM port and response strobes.
// Signals : req/req_addr/req_len (requester -> arbiter), ack (arbiter -> requester),
//           rom_addr/rom_q (glyph ROM), rsp_valid/rsp_last/rsp_data (return path), busy.
// Modports: slave = arbiter side, master = requesters + ROM side.

interface glyph_fetch_arbiter_if
    import glyph_fetch_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = GLYPH_DATA_WIDTH,
    parameter int ADDR_WIDTH = GLYPH_ADDR_WIDTH,
    parameter int LEN_WIDTH  = GLYPH_LEN_WIDTH
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
    logic [NUM_REQ-1:0]            ack;
    logic [ADDR_WIDTH-1:0]         rom_addr;
    logic [DATA_WIDTH-1:0]         rom_q;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic                          rsp_last;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          busy;

    modport slave (
        input  req, req_addr, req_len, rom_q,
        output ack, rom_addr, rsp_valid, rsp_last, rsp_data, busy
    );

    modport master (
        output req, req_addr, req_len, rom_q,
        input  ack, rom_addr, rsp_valid, rsp_last, rsp_data, busy
    );
endinterface

// File: rtl/glyph_fetch_arbiter_rr_arbiter.sv
// rtl/glyph_fetch_arbiter_rr_arbiter.sv - round-robin pick with its own pointer register
//
// Purpose : combinational pick of the first set request searching upward from ptr+1.
// Ports   : clk, rst_n        clock, async active-low reset
//           i_req             request vector
//           i_advance         grant taken this edge; pointer moves to the winner
//           o_gnt_vld         some request is set
//           o_gnt_oh          one-hot winner
//           o_gnt_idx         winner index

module glyph_fetch_arbiter_rr_arbiter
    import glyph_fetch_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic               o_gnt_vld,
    output logic [NUM_REQ-1:0] o_gnt_oh,
    output logic [PTR_W-1:0]   o_gnt_idx
);
    logic [PTR_W-1:0] r_ptr;
    int unsigned      w_j;

    // Scan from the farthest candidate down to ptr+1 so the nearest set bit wins last.
    always_comb begin
        o_gnt_vld = 1'b0;
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        w_j       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_j = rr_wrap(32'(r_ptr), 32'(k), 32'(NUM_REQ));
            if (i_req[w_j]) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = PTR_W'(w_j);
                o_gnt_oh  = NUM_REQ'(1) << w_j;
            end
        end
    end

    // Reset to the last index so requester 0 is first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PTR_W'(NUM_REQ - 1);
        end else if (i_advance) begin
            r_ptr <= o_gnt_idx;
        end
    end
endmodule

// File: rtl/glyph_fetch_arbiter.sv
// rtl/glyph_fetch_arbiter.sv - round-robin burst fetch arbiter for the shared glyph ROM
//
// Purpose : grants one burst (start address + length-1) at a time, streams one ROM
//           address per cycle and tags returning ROM words to their owner.
// Ports   : clk, rst_n   clock, async active-low reset
//           bus (slave)  req/req_addr/req_len in, ack out, rom_addr out, rom_q in,
//                        rsp_valid/rsp_last/rsp_data out, busy out
//           The glyph ROM (1-cycle registered read) hangs off bus.rom_addr/bus.rom_q.

module glyph_fetch_arbiter
    import glyph_fetch_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = GLYPH_DATA_WIDTH,
    parameter int ADDR_WIDTH = GLYPH_ADDR_WIDTH,
    parameter int LEN_WIDTH  = GLYPH_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    glyph_fetch_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    fsm_state_t            r_state;
    logic [NUM_REQ-1:0]    r_ack;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [PTR_W-1:0]      r_owner;
    logic                  r_issue;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic                  r_rsp_last;

    logic                  w_gnt_vld;
    logic [NUM_REQ-1:0]    w_gnt_oh;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic                  w_advance;

    assign w_advance = (r_state == ST_IDLE) && w_gnt_vld;

    glyph_fetch_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (bus.req),
        .i_advance (w_advance),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_oh  (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ack       <= '0;
            r_rom_addr  <= '0;
            r_cnt       <= '0;
            r_owner     <= '0;
            r_issue     <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_last  <= 1'b0;
        end else begin
            r_ack   <= '0;
            r_issue <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_ack      <= w_gnt_oh;
                        r_owner    <= w_gnt_idx;
                        r_rom_addr <= bus.req_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        r_cnt      <= bus.req_len[w_gnt_idx*LEN_WIDTH +: LEN_WIDTH];
                        r_issue    <= 1'b1;
                        r_state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (r_cnt != '0) begin
                        r_rom_addr <= r_rom_addr + ADDR_WIDTH'(1);
                        r_cnt      <= r_cnt - LEN_WIDTH'(1);
                        r_issue    <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // One stage behind the address issue, matching the ROM read latency.
            // r_owner is sampled here, so this register is the delayed owner copy.
            r_rsp_valid <= r_issue ? (NUM_REQ'(1) << r_owner) : '0;
            r_rsp_last  <= r_issue && (r_cnt == '0);
        end
    end

    assign bus.ack       = r_ack;
    assign bus.rom_addr  = r_rom_addr;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_last  = r_rsp_last;
    assign bus.rsp_data  = bus.rom_q;
    assign bus.busy      = (r_state == ST_BURST);
endmodule

// File: tb/tb_glyph_fetch_arbiter.sv
// tb/tb_glyph_fetch_arbiter.sv - scoreboard bench for glyph_fetch_arbiter with an identity ROM

module tb_glyph_fetch_arbiter;
    import glyph_fetch_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int DW = 24;
    localparam int AW = 12;
    localparam int LW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    glyph_fetch_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    glyph_fetch_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Requester drive state, one slot per requester.
    bit          req_b  [N];
    logic [AW-1:0] addr_v [N];
    logic [LW-1:0] len_v  [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.req[i]                  = req_b[i];
            bus.req_addr[i*AW +: AW]    = addr_v[i];
            bus.req_len[i*LW +: LW]     = len_v[i];
        end
    end

    // Identity glyph ROM: word k = k, one-cycle registered read.
    always @(posedge clk) bus.rom_q <= {{(DW-AW){1'b0}}, bus.rom_addr};

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level arbiter.
    typedef struct {
        int cyc;
        int owner;
        int data;
        bit last;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   m_ptr = N - 1;
    int   m_next_free = 0;
    int   m_busy_end = 0;
    logic [N-1:0] exp_ack = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbq.delete();
            m_ptr       = N - 1;
            m_next_free = 0;
            m_busy_end  = 0;
            exp_ack     = '0;
        end else begin
            int w;
            cyc++;
            exp_ack = '0;
            w = -1;
            if (cyc >= m_next_free) begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (req_b[j] && w < 0) w = j;
                end
            end
            if (w >= 0) begin
                int l, a;
                l = int'(len_v[w]);
                a = int'(addr_v[w]);
                exp_ack[w] = 1'b1;
                m_ptr = w;
                for (int k = 0; k <= l; k++)
                    sbq.push_back('{cyc: cyc + 1 + k, owner: w, data: (a + k) % 4096, last: (k == l)});
                m_busy_end  = cyc + l + 1;
                m_next_free = cyc + l + 2;
            end
        end
    end

    // Monitor: compares every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ack", 32'(bus.ack), 32'(exp_ack));
            chk("busy", 32'(bus.busy), 32'(cyc < m_busy_end));
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.owner);
                chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                chk("rsp_last", 32'(bus.rsp_last), 32'(e.last));
            end else begin
                chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
                chk("rsp_last_idle", 32'(bus.rsp_last), 32'd0);
            end
        end
    end

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        addr_v[i] = a;
        len_v[i]  = l;
        req_b[i]  = 1'b1;
    endtask

    task automatic wait_ack(input int i);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.ack[i]) begin
                got = 1'b1;
                break;
            end
        end
        req_b[i] = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: requester %0d got no ack, required one within 300 cycles", i);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(bus.ack), 32'd0);
        chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_last"}, 32'(bus.rsp_last), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic run_rand(input int i, input int bursts);
        logic [AW-1:0] a;
        for (int n = 0; n < bursts; n++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            a = ($urandom_range(0, 1) == 1 ? OBSTACLE_BASE : MARIO_BASE) + AW'($urandom_range(0, 1535));
            set_req(i, a, LW'($urandom_range(0, 31)));
            if ($urandom_range(0, 4) == 0) begin
                // Short pulse: may or may not be granted; the model decides.
                @(negedge clk);
                req_b[i] = 1'b0;
            end else begin
                wait_ack(i);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            req_b[i]  = 1'b0;
            addr_v[i] = '0;
            len_v[i]  = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // 1: single 4-word burst
        @(negedge clk);
        set_req(0, 12'h010, 5'd3);
        wait_ack(0);
        repeat (8) @(negedge clk);

        // 2: both held high with single-word bursts
        set_req(0, 12'h020, 5'd0);
        set_req(1, 12'h040, 5'd0);
        repeat (12) @(negedge clk);
        req_b[0] = 1'b0;
        req_b[1] = 1'b0;
        repeat (6) @(negedge clk);

        // 3: address wrap
        set_req(1, 12'hFFE, 5'd3);
        wait_ack(1);
        repeat (8) @(negedge clk);

        // 4: req0 arrives during a 32-word burst of req1
        set_req(1, 12'h100, 5'd31);
        wait_ack(1);
        repeat (2) @(negedge clk);
        set_req(0, 12'hA00, 5'd1);
        wait_ack(0);
        repeat (8) @(negedge clk);

        // 5: reset mid-burst after two words
        set_req(0, 12'h200, 5'd7);
        wait_ack(0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 12'h300, 5'd1);
        set_req(1, 12'h400, 5'd1);
        wait_ack(0);
        wait_ack(1);
        repeat (8) @(negedge clk);

        // 6: req1 pulsed and withdrawn while req0 bursts
        set_req(0, 12'h500, 5'd5);
        wait_ack(0);
        @(negedge clk);
        set_req(1, 12'h600, 5'd2);
        @(negedge clk);
        req_b[1] = 1'b0;
        repeat (12) @(negedge clk);

        // Randomised contention
        fork
            run_rand(0, 14);
            run_rand(1, 14);
        join

        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sbq.size() == 0) break;
        end
        repeat (4) @(negedge clk);
        chk("drain", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
